// File: rtl/module_bus_interconnect_n.sv
// ============================================================================
//  Module      : module_bus_interconnect_n
//  Description : N-slot memory-mapped bus interconnect with per-slot wait
//                states. Decodes the master address into a one-hot slot
//                select, issues a single-cycle write strobe, and returns
//                registered read data with a ready/error handshake.
//  Optional    : BUS_ERR_LOG_EN -- when defined, keeps a saturating count
//                of unmapped accesses and the first faulting address.
//  Ports       : clk_i, rst_i            clock, sync active-high reset
//                req_i, we_i             master request / write enable
//                addr_i, wdata_i         master address / write data
//                rdata_o, ready_o, err_o master response
//                sel_o, we_o             one-hot slot select / write strobe
//                addr_o, wdata_o         latched address / data to slaves
//                rdata_i                 packed slave read data
//                err_addr_o, err_cnt_o   error log (zero when logging off)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module module_bus_interconnect_n #(
  parameter int                    N_SLAVES    = 6,
  parameter int                    ADDR_W      = 32,
  parameter int                    DATA_W      = 32,
  parameter int                    SLOT_SHIFT  = 12,
  parameter logic [ADDR_W-1:0]     BASE_TAG    = '0,
  parameter logic [4*N_SLAVES-1:0] WAIT_CYCLES = 24'h200000
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_i,
  input  logic                         we_i,
  input  logic [ADDR_W-1:0]            addr_i,
  input  logic [DATA_W-1:0]            wdata_i,
  output logic [DATA_W-1:0]            rdata_o,
  output logic                         ready_o,
  output logic                         err_o,
  output logic [N_SLAVES-1:0]          sel_o,
  output logic [N_SLAVES-1:0]          we_o,
  output logic [ADDR_W-1:0]            addr_o,
  output logic [DATA_W-1:0]            wdata_o,
  input  logic [N_SLAVES*DATA_W-1:0]   rdata_i,
  output logic [ADDR_W-1:0]            err_addr_o,
  output logic [7:0]                   err_cnt_o
);

  localparam int IDX_W   = $clog2(N_SLAVES);
  localparam int TAG_LSB = SLOT_SHIFT + IDX_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               we_q;
  logic               err_q;
  logic [IDX_W-1:0]   slot_q;
  logic [3:0]         cnt;

  logic [IDX_W-1:0]   req_idx;
  logic               req_mapped;

  // Slot index and tag of the incoming request; the tag is compared as the
  // full address shifted down so BASE_TAG needs no separate width.
  assign req_idx    = addr_i[SLOT_SHIFT +: IDX_W];
  assign req_mapped = ((addr_i >> TAG_LSB) == BASE_TAG) &&
                      (int'(req_idx) < N_SLAVES);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and strobe outputs
  always_comb begin
    state_next = state;
    sel_o      = '0;
    we_o       = '0;
    ready_o    = 1'b0;
    err_o      = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_i) begin
          state_next = req_mapped ? S_ACCESS : S_RESP;
        end
      end
      S_ACCESS: begin
        sel_o = {{(N_SLAVES-1){1'b0}}, 1'b1} << slot_q;
        if (cnt == 4'd0) begin
          state_next = S_RESP;
          if (we_q) begin
            we_o = sel_o;
          end
        end
      end
      S_RESP: begin
        ready_o    = 1'b1;
        err_o      = err_q;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // Reset wins in the same cycle: a write strobe coinciding with reset
    // must never reach a slave.
    if (rst_i) begin
      sel_o   = '0;
      we_o    = '0;
      ready_o = 1'b0;
      err_o   = 1'b0;
    end
  end

  // Request latching, wait counting and read capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      slot_q  <= '0;
      cnt     <= '0;
      addr_o  <= '0;
      wdata_o <= '0;
      rdata_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            addr_o  <= addr_i;
            wdata_o <= wdata_i;
            err_q   <= ~req_mapped;
            if (req_mapped) begin
              slot_q <= req_idx;
              cnt    <= WAIT_CYCLES[4*req_idx +: 4];
            end else begin
              // Error responses present zero read data.
              rdata_o <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!we_q) begin
            rdata_o <= rdata_i[slot_q*DATA_W +: DATA_W];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BUS_ERR_LOG_EN
  logic [ADDR_W-1:0] err_addr_q;
  logic [7:0]        err_cnt_q;

  // A zero count marks "no error seen yet" because the count saturates
  // rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else if (state == S_RESP && err_q) begin
      if (err_cnt_q == 8'd0) begin
        err_addr_q <= addr_o;
      end
      if (err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign err_addr_o = err_addr_q;
  assign err_cnt_o  = err_cnt_q;
`else
  assign err_addr_o = '0;
  assign err_cnt_o  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_module_bus_interconnect_n.sv
// ============================================================================
//  Module      : tb_module_bus_interconnect_n
//  Description : Randomized self-checking bench for module_bus_interconnect_n
//                against a transaction-level timing model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_module_bus_interconnect_n;

  localparam logic [23:0] WAITS = 24'h200000;

  logic         clk = 1'b0;
  logic         rst;
  logic         req;
  logic         we;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [191:0] rdata_in;
  logic [31:0]  rdata_o;
  logic         ready_o;
  logic         err_o;
  logic [5:0]   sel_o;
  logic [5:0]   we_o;
  logic [31:0]  addr_o;
  logic [31:0]  wdata_o;
  logic [31:0]  err_addr_o;
  logic [7:0]   err_cnt_o;

  module_bus_interconnect_n dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .we_i       (we),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .rdata_o    (rdata_o),
    .ready_o    (ready_o),
    .err_o      (err_o),
    .sel_o      (sel_o),
    .we_o       (we_o),
    .addr_o     (addr_o),
    .wdata_o    (wdata_o),
    .rdata_i    (rdata_in),
    .err_addr_o (err_addr_o),
    .err_cnt_o  (err_cnt_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Transaction model: one outstanding transfer, described by the cycle it
  // was accepted in; every output is a function of the phase since then.
  bit          m_active;
  int          m_tacc;
  bit          m_map;
  bit          m_we;
  int          m_slot;
  int          m_wait;
  logic [31:0] m_addr;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  logic [31:0] exp_rdata;
  int          exp_ecnt;
  logic [31:0] exp_eaddr;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int wait_of(int s);
    return int'((WAITS >> (4*s)) & 24'hF);
  endfunction

  function automatic bit is_mapped(logic [31:0] a);
    return ((a >> 15) == 32'd0) && (((a >> 12) & 32'd7) < 32'd6);
  endfunction

  // Apply the effect of the clock edge that closes cycle k (inputs still
  // hold the values presented during cycle k).
  task automatic model_edge(int k);
    int p;
    int len;
    bit busy;
    if (rst) begin
      m_active  = 1'b0;
      exp_addr  = '0;
      exp_wdata = '0;
      exp_rdata = '0;
      exp_ecnt  = 0;
      exp_eaddr = '0;
      return;
    end
    busy = 1'b0;
    if (m_active) begin
      p    = k - m_tacc;
      len  = m_map ? m_wait + 3 : 2;
      busy = (p >= 1) && (p <= len - 1);
      if (m_map && !m_we && p == m_wait + 1)
        exp_rdata = rdata_in[m_slot*32 +: 32];
      if (!m_map && p == 1) begin
        if (exp_ecnt == 0) exp_eaddr = m_addr;
        if (exp_ecnt < 255) exp_ecnt++;
      end
    end
    if (!busy && req) begin
      m_active  = 1'b1;
      m_tacc    = k;
      m_we      = we;
      m_addr    = addr;
      m_map     = is_mapped(addr);
      m_slot    = int'((addr >> 12) & 32'd7);
      m_wait    = m_map ? wait_of(m_slot) : 0;
      exp_addr  = addr;
      exp_wdata = wdata;
      if (!m_map) exp_rdata = '0;
    end
  endtask

  task automatic check_cycle(int c);
    logic [5:0] e_sel;
    logic [5:0] e_we;
    bit         e_rdy;
    bit         e_err;
    int         p;
    e_sel = '0;
    e_we  = '0;
    e_rdy = 1'b0;
    e_err = 1'b0;
    if (m_active && !rst) begin
      p = c - m_tacc;
      if (m_map) begin
        if (p >= 1 && p <= m_wait + 1) e_sel = 6'(1 << m_slot);
        if (p == m_wait + 1 && m_we)   e_we  = e_sel;
        if (p == m_wait + 2)           e_rdy = 1'b1;
      end else if (p == 1) begin
        e_rdy = 1'b1;
        e_err = 1'b1;
      end
    end
    chk("sel_o",   64'(sel_o),   64'(e_sel));
    chk("we_o",    64'(we_o),    64'(e_we));
    chk("ready_o", 64'(ready_o), 64'(e_rdy));
    chk("err_o",   64'(err_o),   64'(e_err));
    chk("addr_o",  64'(addr_o),  64'(exp_addr));
    chk("wdata_o", 64'(wdata_o), 64'(exp_wdata));
    chk("rdata_o", 64'(rdata_o), 64'(exp_rdata));
`ifdef BUS_ERR_LOG_EN
    chk("err_cnt_o",  64'(err_cnt_o),  64'(exp_ecnt));
    chk("err_addr_o", 64'(err_addr_o), 64'(exp_eaddr));
`else
    chk("err_cnt_o",  64'(err_cnt_o),  64'd0);
    chk("err_addr_o", 64'(err_addr_o), 64'd0);
`endif
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom_range(0, 7) << 12) | ($urandom & 32'hFFF);
    if ($urandom_range(0, 7) == 0)
      a = a | ($urandom_range(1, 131071) << 15);
    return a;
  endfunction

  // mode 0: reset, 1: random traffic, 2: unmapped flood, 3: back-to-back reads
  task automatic step(int mode);
    @(posedge clk);
    cyc++;
    model_edge(cyc - 1);
    #1;
    case (mode)
      0: begin
        rst = 1'b1; req = 1'b0;
      end
      1: begin
        rst   = ($urandom_range(0, 49) == 0);
        req   = $urandom_range(0, 1) == 1;
        we    = $urandom_range(0, 1) == 1;
        addr  = rand_addr();
        wdata = $urandom;
      end
      2: begin
        rst   = 1'b0;
        req   = 1'b1;
        we    = $urandom_range(0, 1) == 1;
        addr  = ($urandom_range(6, 7) << 12) | ($urandom & 32'hFFF);
        if ($urandom_range(0, 3) == 0) addr = addr | 32'h0001_0000;
        wdata = $urandom;
      end
      default: begin
        rst   = 1'b0;
        req   = 1'b1;
        we    = 1'b0;
        addr  = ($urandom_range(0, 1) == 1) ? 32'h0000_5008 : 32'h0000_0010;
        wdata = $urandom;
      end
    endcase
    for (int s = 0; s < 6; s++) rdata_in[s*32 +: 32] = $urandom;
    @(negedge clk);
    check_cycle(cyc);
  endtask

  initial begin
    rst      = 1'b1;
    req      = 1'b0;
    we       = 1'b0;
    addr     = '0;
    wdata    = '0;
    rdata_in = '0;
    m_active = 1'b0;
    m_tacc   = 0;
    m_map    = 1'b0;
    m_we     = 1'b0;
    m_slot   = 0;
    m_wait   = 0;
    m_addr   = '0;
    exp_addr = '0;
    exp_wdata = '0;
    exp_rdata = '0;
    exp_ecnt  = 0;
    exp_eaddr = '0;

    repeat (3)    step(0);
    repeat (3000) step(1);
    repeat (2)    step(0);
    repeat (200)  step(3);
    repeat (2)    step(0);
    repeat (700)  step(2);
    repeat (500)  step(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
